// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-cycle core.
// Holds the instruction address, selects the next address from the
// halt/jump/branch/sequential controls, owns the IDLE/RUN/HALTED state
// and counts retired instructions.
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        zero,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic [31:0] extended_immediate,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        running,
    output logic        halted,
    output logic [31:0] instr_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [1:0]  state;
    logic [31:0] next_pc;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic        branch_taken;

    assign pc_plus4 = pc + 32'd4;
    assign running  = (state == RUN);
    assign halted   = (state == HALTED);

    // Next-address select: halt > jump > taken branch > sequential.
    always_comb begin
        branch_addr  = pc_plus4 + (extended_immediate << 2);
        jump_addr    = {pc_plus4[31:28], jump_target, 2'b00};
        branch_taken = branch && (zero ^ branch_ne);
        next_pc      = pc_plus4;
        if (halt) begin
            next_pc = pc;
        end else if (jump) begin
            next_pc = jump_addr;
        end else if (branch_taken) begin
            next_pc = branch_addr;
        end
    end

    // State, PC and retired-count update; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC_ALIGNED;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (run) begin
                        instr_count <= instr_count + 32'd1;
                        if (halt) begin
                            state <= HALTED;
                        end else begin
                            pc <= next_pc;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
